// File: rtl/oscillator_bank.sv
// Multi-voice two-segment (FRONT/BACK) oscillator bank: shared prescaler, round-robin serial phase divider.
// Optional OSCILLATOR_BANK_HARD_SYNC_EN adds sync_mask: voice v restarts when voice v-1 wraps BACK->FRONT.
module oscillator_bank #(
  parameter int unsigned NUM_VOICES       = 8,
  parameter int unsigned PERIOD_WIDTH     = 20,
  parameter int unsigned PERCENT_WIDTH    = 8,
  parameter int unsigned PHASE_WIDTH      = 12,
  parameter int unsigned GENERATION_TICKS = 1,
  localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                                     clock_50_000_000,
  input  logic                                     reset_l,
  input  logic [NUM_VOICES-1:0]                    clear,
  input  logic [NUM_VOICES-1:0][PERIOD_WIDTH-1:0]  period,
  input  logic [NUM_VOICES-1:0][PERCENT_WIDTH-1:0] duty_cycle,
`ifdef OSCILLATOR_BANK_HARD_SYNC_EN
  input  logic [NUM_VOICES-1:0]                    sync_mask,
`endif
  output logic [NUM_VOICES-1:0]                    voice_state,
  output logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0]   voice_phase,
  output logic                                     phase_valid,
  output logic [VOICE_W-1:0]                       phase_voice
);

  localparam int unsigned PRESC_W = (GENERATION_TICKS > 1) ? $clog2(GENERATION_TICKS) : 1;
  localparam int unsigned PROD_W  = PERIOD_WIDTH + PERCENT_WIDTH;
  localparam int unsigned ITER_W  = (PHASE_WIDTH > 1) ? $clog2(PHASE_WIDTH) : 1;

  typedef enum logic [1:0] {DIV_LOAD, DIV_ITER, DIV_WRITE} div_state_e;

  logic [PRESC_W-1:0]                       presc_q;
  logic                                     tick;
  logic [NUM_VOICES-1:0][PERIOD_WIDTH-1:0]  duty_ticks;
  logic [NUM_VOICES-1:0][PERIOD_WIDTH-1:0]  target_live;
  logic [NUM_VOICES-1:0]                    wrap;
  logic [NUM_VOICES-1:0]                    sync_hit;
  logic [NUM_VOICES-1:0]                    state_q, state_d;
  logic [NUM_VOICES-1:0][PERIOD_WIDTH-1:0]  count_q, count_d;

  div_state_e                               div_q;
  logic [VOICE_W-1:0]                       ptr_q;
  logic [ITER_W-1:0]                        iter_q;
  logic [PERIOD_WIDTH-1:0]                  rem_q;
  logic [PERIOD_WIDTH-1:0]                  divisor_q;
  logic [PHASE_WIDTH-1:0]                   quot_q;
  logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0]   phase_q;
  logic                                     phase_valid_q;
  logic [VOICE_W-1:0]                       phase_voice_q;
  logic [PERIOD_WIDTH:0]                    rem_sh;
  logic                                     rem_ge;

  // Shared prescaler: tick on the last cycle of each GENERATION_TICKS window.
  assign tick = (presc_q == PRESC_W'(GENERATION_TICKS - 1));

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l)  presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PRESC_W'(1);
  end

  // Live segment target from the full-width period*duty product.
  always_comb begin
    duty_ticks  = '0;
    target_live = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      duty_ticks[v]  = PERIOD_WIDTH'((PROD_W'(period[v]) * PROD_W'(duty_cycle[v])) >> PERCENT_WIDTH);
      target_live[v] = state_q[v] ? (period[v] - duty_ticks[v]) : duty_ticks[v];
    end
  end

`ifdef OSCILLATOR_BANK_HARD_SYNC_EN
  logic [NUM_VOICES-1:0] back_wrap;
  logic                  unused_sync_lsb;
  assign unused_sync_lsb = sync_mask[0];
`endif

  // Per-voice segment counters; the target==0 term keeps target-1 from underflowing into a wrap miss.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wrap     = '0;
    sync_hit = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      wrap[v] = (target_live[v] == '0) || (count_q[v] >= (target_live[v] - PERIOD_WIDTH'(1)));
    end
`ifdef OSCILLATOR_BANK_HARD_SYNC_EN
    back_wrap = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      back_wrap[v] = tick && !clear[v] && state_q[v] && wrap[v];
    end
    for (int v = 1; v < NUM_VOICES; v++) begin
      sync_hit[v] = back_wrap[v-1] && sync_mask[v];
    end
`endif
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (clear[v] || sync_hit[v]) begin
        state_d[v] = 1'b0;
        count_d[v] = '0;
      end else if (tick) begin
        if (wrap[v]) begin
          state_d[v] = ~state_q[v];
          count_d[v] = '0;
        end else begin
          count_d[v] = count_q[v] + PERIOD_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Restoring step; count < target keeps the remainder within PERIOD_WIDTH bits.
  assign rem_sh = {rem_q, 1'b0};
  assign rem_ge = (rem_sh >= {1'b0, divisor_q});

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      div_q         <= DIV_LOAD;
      ptr_q         <= '0;
      iter_q        <= '0;
      rem_q         <= '0;
      divisor_q     <= '0;
      quot_q        <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      phase_voice_q <= '0;
    end else begin
      case (div_q)
        DIV_LOAD: begin
          rem_q         <= count_q[ptr_q];
          divisor_q     <= target_live[ptr_q];
          quot_q        <= '0;
          iter_q        <= '0;
          phase_valid_q <= 1'b0;
          div_q         <= DIV_ITER;
        end
        DIV_ITER: begin
          rem_q  <= rem_ge ? PERIOD_WIDTH'(rem_sh - {1'b0, divisor_q}) : PERIOD_WIDTH'(rem_sh);
          quot_q <= PHASE_WIDTH'({quot_q, rem_ge});
          iter_q <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(PHASE_WIDTH - 1)) div_q <= DIV_WRITE;
        end
        DIV_WRITE: begin
          phase_q[ptr_q] <= (divisor_q == '0) ? '0 : quot_q;
          phase_valid_q  <= 1'b1;
          phase_voice_q  <= ptr_q;
          ptr_q          <= (ptr_q == VOICE_W'(NUM_VOICES - 1)) ? '0 : ptr_q + VOICE_W'(1);
          div_q          <= DIV_LOAD;
        end
        default: div_q <= DIV_LOAD;
      endcase
    end
  end

  assign voice_state = state_q;
  assign voice_phase = phase_q;
  assign phase_valid = phase_valid_q;
  assign phase_voice = phase_voice_q;

endmodule
